// File: rtl/insn_fetch.sv
// Instruction fetch: PC, credit-limited imem request port and an in-order
// {insn, pc} buffer feeding the decoder; redirect flushes queued and in-flight words.
module insn_fetch #(
  parameter int unsigned       LEN_INSN = 32,
  parameter int unsigned       LEN_PC   = 32,
  parameter logic [LEN_PC-1:0] RESET_PC = '0,
  parameter int unsigned       QDEPTH   = 2
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req_o,
  output logic [LEN_PC-1:0]   imem_addr_o,
  input  logic                imem_gnt_i,
  input  logic                imem_rvalid_i,
  input  logic [LEN_INSN-1:0] imem_rdata_i,
  output logic [LEN_INSN-1:0] insn_o,
  output logic [LEN_PC-1:0]   pc_o,
  output logic                insn_valid_o,
  input  logic                insn_ready_i,
  input  logic                redirect_i,
  input  logic [LEN_PC-1:0]   redirect_pc_i
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned CW = $clog2(QDEPTH + 1);
  localparam int unsigned SW = CW + 1;

  logic [LEN_PC-1:0]   pc;
  logic [LEN_PC-1:0]   rpc;
  logic [CW-1:0]       outstanding;
  logic [CW-1:0]       outstanding_nxt;
  logic [CW-1:0]       drop;
  logic [CW-1:0]       count;
  logic [PW-1:0]       head;
  logic [PW-1:0]       tail;
  logic [LEN_INSN-1:0] insn_mem [QDEPTH];
  logic [LEN_PC-1:0]   pc_mem   [QDEPTH];
  logic                rst_state;
  logic                xfer;
  logic                grant;
  logic                ret;
  logic                keep;
  logic [SW-1:0]       credits;

  assign imem_addr_o  = pc;
  assign insn_valid_o = (count != '0);
  assign insn_o       = insn_mem[head];
  assign pc_o         = pc_mem[head];

  // Credits = in-flight + buffered; a same-cycle consume frees one.
  always_comb begin
    xfer            = insn_valid_o & insn_ready_i;
    credits         = SW'(outstanding) + SW'(count) - SW'(xfer);
    imem_req_o      = !rst_state && (credits < SW'(QDEPTH));
    grant           = imem_req_o & imem_gnt_i;
    ret             = imem_rvalid_i & (outstanding != '0);
    keep            = ret & (drop == '0) & !redirect_i;
    outstanding_nxt = outstanding + CW'(grant) - CW'(ret);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      rpc         <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      count       <= '0;
      head        <= '0;
      tail        <= '0;
      rst_state   <= 1'b1;
      for (int i = 0; i < int'(QDEPTH); i++) begin
        insn_mem[i] <= '0;
        pc_mem[i]   <= RESET_PC;
      end
    end else begin
      rst_state   <= 1'b0;
      outstanding <= outstanding_nxt;
      if (redirect_i) begin
        // A grant this cycle still issues at the old PC but is counted for discard.
        pc    <= redirect_pc_i;
        rpc   <= redirect_pc_i;
        drop  <= outstanding_nxt;
        count <= '0;
        head  <= '0;
        tail  <= '0;
      end else begin
        if (grant) begin
          pc <= pc + LEN_PC'(1);
        end
        if (ret && (drop != '0)) begin
          drop <= drop - CW'(1);
        end
        if (keep) begin
          insn_mem[tail] <= imem_rdata_i;
          pc_mem[tail]   <= rpc;
          tail           <= tail + PW'(1);
          rpc            <= rpc + LEN_PC'(1);
        end
        if (xfer) begin
          head <= head + PW'(1);
        end
        count <= count + CW'(keep) - CW'(xfer);
      end
    end
  end

endmodule

// File: tb/tb_insn_fetch.sv
// Bench for insn_fetch: directed cycle tables, hand-written redirect sequences and
// randomized traffic checked against an epoch-tagged queue model of the fetch stage.
module tb_insn_fetch;

  localparam int unsigned QDEPTH  = 2;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFE;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, gnt, rvalid, valid, ready, redirect;
  logic [31:0] addr, rdata, insn, ipc, redirect_pc;
  logic        w_req, w_rvalid, w_valid;
  logic [31:0] w_addr, w_rdata, w_insn, w_pc;

  always #5 clk = ~clk;

  insn_fetch #(.LEN_INSN(32), .LEN_PC(32), .RESET_PC(32'h0), .QDEPTH(QDEPTH)) u_dut (
    .clk(clk), .rst(rst),
    .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt),
    .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
    .insn_o(insn), .pc_o(ipc), .insn_valid_o(valid), .insn_ready_i(ready),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc)
  );

  insn_fetch #(.LEN_INSN(32), .LEN_PC(32), .RESET_PC(WRAP_PC), .QDEPTH(QDEPTH)) u_wrap (
    .clk(clk), .rst(rst),
    .imem_req_o(w_req), .imem_addr_o(w_addr), .imem_gnt_i(1'b1),
    .imem_rvalid_i(w_rvalid), .imem_rdata_i(w_rdata),
    .insn_o(w_insn), .pc_o(w_pc), .insn_valid_o(w_valid), .insn_ready_i(1'b1),
    .redirect_i(1'b0), .redirect_pc_i(32'h0)
  );

  typedef struct { logic [31:0] insn; logic [31:0] pc; } word_t;
  typedef struct { logic [31:0] addr; int due; int epoch; } req_t;
  typedef struct { bit rst; bit ready; bit req; bit valid; logic [31:0] insn; } vec_t;

  word_t       exp_q[$];
  req_t        fl_q[$];
  int          epoch, cyc, last_due, lat_min, lat_max;
  logic [31:0] exp_pc, key;
  bit          first, spurious_en;
  bit          w_grant_q;
  logic [31:0] w_addr_q;
  int          w_idx, w_max;
  int          checks, errors;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Reference: buffered words in a queue, in-flight reads tagged with the redirect
  // epoch at grant time; a read returning under a newer epoch is stale.
  task automatic model_eval();
    bit    xf, gr, exv, exr;
    word_t w;
    req_t  r;
    if (rst) begin
      check("rst_req", 32'(req), 32'd0);
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_insn", insn, 32'd0);
      check("rst_pc", ipc, 32'd0);
      check("rst_addr", addr, 32'd0);
      check("w_rst_valid", 32'(w_valid), 32'd0);
      check("w_rst_addr", w_addr, WRAP_PC);
      exp_q.delete();
      fl_q.delete();
      epoch = 0; exp_pc = 32'h0; first = 1'b1; last_due = cyc;
      w_idx = 0; w_grant_q = 1'b0;
      return;
    end
    exv = exp_q.size() > 0;
    xf  = exv && ready;
    exr = !first && ((fl_q.size() + exp_q.size() - int'(xf)) < int'(QDEPTH));
    check("req", 32'(req), 32'(exr));
    check("addr", addr, exp_pc);
    check("valid", 32'(valid), 32'(exv));
    if (exv) begin
      check("insn", insn, exp_q[0].insn);
      check("pc", ipc, exp_q[0].pc);
    end
    gr = exr && gnt;
    if (xf) void'(exp_q.pop_front());
    if (rvalid && fl_q.size() > 0) begin
      r = fl_q.pop_front();
      if (!redirect && r.epoch == epoch) begin
        w.insn = r.addr ^ key;
        w.pc   = r.addr;
        exp_q.push_back(w);
      end
    end
    if (gr) begin
      r.addr  = exp_pc;
      r.epoch = epoch;
      r.due   = cyc + int'($urandom_range(lat_max, lat_min));
      if (r.due <= last_due) r.due = last_due + 1;
      last_due = r.due;
      fl_q.push_back(r);
      exp_pc = exp_pc + 32'd1;
    end
    if (redirect) begin
      epoch++;
      exp_q.delete();
      exp_pc = redirect_pc;
    end
    first = 1'b0;
    if (w_valid) begin
      check("w_pc", w_pc, WRAP_PC + 32'(w_idx));
      check("w_insn", w_insn, WRAP_PC + 32'(w_idx));
      w_idx++;
      if (w_idx > w_max) w_max = w_idx;
    end
    w_grant_q = w_req;
    w_addr_q  = w_addr;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    cyc++;
    if (fl_q.size() > 0 && fl_q[0].due <= cyc) begin
      rvalid = 1'b1;
      rdata  = fl_q[0].addr ^ key;
    end else if (spurious_en && fl_q.size() == 0 && $urandom_range(7, 0) == 0) begin
      rvalid = 1'b1;
      rdata  = $urandom;
    end else begin
      rvalid = 1'b0;
      rdata  = $urandom;
    end
    w_rvalid = w_grant_q;
    w_rdata  = w_addr_q;
  endtask

  task automatic tick();
    @(negedge clk);
    model_eval();
    advance();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_valid(string name, logic [31:0] exp_pcv, int bound);
    int n = 0;
    @(negedge clk);
    while (!valid && n < bound) begin
      model_eval();
      advance();
      @(negedge clk);
      n++;
    end
    check({name, "_valid"}, 32'(valid), 32'd1);
    if (valid) check({name, "_pc"}, ipc, exp_pcv);
    model_eval();
    advance();
  endtask

  vec_t tbl[19];

  initial begin
    tbl[0]  = '{1, 1, 0, 0, 32'd0};
    tbl[1]  = '{0, 1, 0, 0, 32'd0};
    tbl[2]  = '{0, 1, 1, 0, 32'd0};
    tbl[3]  = '{0, 1, 1, 0, 32'd0};
    tbl[4]  = '{0, 1, 1, 1, 32'd0};
    tbl[5]  = '{0, 1, 1, 1, 32'd1};
    tbl[6]  = '{0, 1, 1, 1, 32'd2};
    tbl[7]  = '{0, 1, 1, 1, 32'd3};
    tbl[8]  = '{1, 0, 0, 0, 32'd0};
    tbl[9]  = '{0, 0, 0, 0, 32'd0};
    tbl[10] = '{0, 0, 1, 0, 32'd0};
    tbl[11] = '{0, 0, 1, 0, 32'd0};
    tbl[12] = '{0, 0, 0, 1, 32'd0};
    tbl[13] = '{0, 0, 0, 1, 32'd0};
    tbl[14] = '{0, 0, 0, 1, 32'd0};
    tbl[15] = '{0, 1, 1, 1, 32'd0};
    tbl[16] = '{0, 1, 1, 1, 32'd1};
    tbl[17] = '{0, 1, 1, 1, 32'd2};
    tbl[18] = '{0, 1, 1, 1, 32'd3};

    checks = 0; errors = 0; cyc = 0; epoch = 0; last_due = 0;
    lat_min = 1; lat_max = 1; key = 32'h0; spurious_en = 1'b0;
    exp_pc = 32'h0; first = 1'b1; w_idx = 0; w_max = 0; w_grant_q = 1'b0; w_addr_q = 32'h0;
    rst = 1'b1; gnt = 1'b1; ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    rvalid = 1'b0; rdata = 32'h0; w_rvalid = 1'b0; w_rdata = 32'h0;

    // Directed tables: streaming with ready high, then a stall that fills the buffer.
    foreach (tbl[i]) begin
      rst   = tbl[i].rst;
      ready = tbl[i].ready;
      @(negedge clk);
      check($sformatf("tbl%0d_req", i), 32'(req), 32'(tbl[i].req));
      check($sformatf("tbl%0d_valid", i), 32'(valid), 32'(tbl[i].valid));
      if (tbl[i].valid || tbl[i].rst) begin
        check($sformatf("tbl%0d_insn", i), insn, tbl[i].insn);
        check($sformatf("tbl%0d_pc", i), ipc, tbl[i].insn);
      end
      model_eval();
      advance();
    end
    rst = 1'b0;
    check("wrap_delivered", 32'(w_max >= 4), 32'd1);

    // Redirect with two reads in flight on a 3-cycle memory.
    ready = 1'b1; lat_min = 3; lat_max = 3;
    do_reset();
    for (int n = 0; n < 20 && fl_q.size() != 2; n++) tick();
    redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    wait_valid("c_first", 32'h100, 20);
    repeat (6) tick();

    // Redirect coinciding with a grant, a return and a transfer.
    lat_min = 1; lat_max = 1;
    do_reset();
    repeat (6) tick();
    redirect = 1'b1; redirect_pc = 32'h200;
    @(negedge clk);
    check("d_xfer_valid", 32'(valid), 32'd1);
    check("d_xfer_pc", ipc, 32'd3);
    check("d_req", 32'(req), 32'd1);
    check("d_rvalid_seen", 32'(rvalid), 32'd1);
    model_eval();
    advance();
    redirect = 1'b0;
    @(negedge clk);
    check("d_gap1_valid", 32'(valid), 32'd0);
    check("d_new_addr", addr, 32'h200);
    model_eval();
    advance();
    @(negedge clk);
    check("d_gap2_valid", 32'(valid), 32'd0);
    model_eval();
    advance();
    @(negedge clk);
    check("d_first_valid", 32'(valid), 32'd1);
    check("d_first_pc", ipc, 32'h200);
    model_eval();
    advance();

    // Back-to-back redirects with reads in flight.
    lat_min = 3; lat_max = 3;
    do_reset();
    repeat (3) tick();
    redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect_pc = 32'h80;
    tick();
    redirect = 1'b0;
    wait_valid("e_first", 32'h80, 20);
    repeat (6) tick();

    // Randomized traffic: variable latency, grant/ready gaps, redirects, stray rvalids, resets.
    rst = 1'b1;
    key = 32'h5A5A_0F0F;
    tick();
    rst = 1'b0;
    lat_min = 1; lat_max = 3; spurious_en = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      ready       = ($urandom_range(3, 0) != 0);
      gnt         = ($urandom_range(3, 0) != 0);
      redirect    = ($urandom_range(19, 0) == 0);
      redirect_pc = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(3, 0))) : $urandom;
      rst         = ($urandom_range(499, 0) == 0);
      tick();
    end
    rst = 1'b0; redirect = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
